uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter that drives the PYNQ-Z2 uart_tx pin from CPU store instructions. It sits downstream of PipelinedCPU's data-memory port, beside DataMemory, and is selected by address decode on dmem_addr. Stores are buffered in a FIFO and serialised as 8N1 frames, LSB first, at a fixed baud rate derived from cpu_clk. A status register lets software poll FIFO full/empty state and transmitter busy.

Parameters:
CLK_FREQ_HZ, 10_000_000, frequency of clk in Hz.
BAUD, 115200, line rate in bit/s.
FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
DIV (localparam), (CLK_FREQ_HZ + BAUD/2) / BAUD, clk cycles per bit (87 at defaults).

Ports:
clk  in  1  CPU clock (cpu_clk)
rst  in  1  synchronous active-high reset
sel  in  1  address decode hit for the UART window
we  in  1  store strobe, qualified by sel
re  in  1  load strobe, qualified by sel
addr  in  1  word offset: 0 = TXDATA, 1 = STATUS (dmem_addr[2])
wdata  in  8  store data byte (dmem_wdata[7:0])
rdata  out  32  registered read data
uart_tx  out  1  serial line, idle high
tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty

Behaviour:
- Reset, synchronous, active-high: uart_tx=1, rdata=0, tx_busy=0, FIFO emptied, overflow=0, FSM=IDLE, baud counter=0, bit index=0. Reset asserted mid-frame aborts the frame; uart_tx returns high on the next edge.
- TXDATA write (sel&we&addr==0): pushes wdata when the FIFO is not full. When full, the byte is dropped and sticky overflow is set. A pop in the same cycle as a push into a full FIFO frees a slot, so the push is accepted.
- STATUS write (sel&we&addr==1): writing 1 to bit3 clears overflow. Other bits are ignored.
- Read (sel&re): rdata updates on the next edge. TXDATA reads 0. STATUS layout: [0] full, [1] empty, [2] shifter active (FSM!=IDLE), [3] overflow, [12:8] FIFO count (0..FIFO_DEPTH), all other bits 0. When no read is active, rdata holds its value.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. When the registered FIFO count is non-zero, pop into the shift register, clear the baud counter and bit index, and go to START.
  - START: uart_tx=0 for DIV cycles, then go to DATA.
  - DATA: uart_tx=shift[0] for DIV cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: uart_tx=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..DIV-1. A bit period ends when the counter equals DIV-1; the counter then wraps to 0.
- Frame length is exactly 10*DIV cycles.
- Latency: a store at edge N is visible in count at N+1. IDLE pops at edge N+1, and uart_tx falls at edge N+2.
- Push into an empty FIFO is not popped in the same cycle; pop decisions use registered state only.
- tx_busy = (state!=IDLE) | !empty, registered-equivalent, with no glitches between back-to-back frames.
- uart_tx is driven directly from a flop (no combinational path to the pin).

Decomposition:
- riscv_pkg: UART_TXDATA_ADDR = 32'h8000_0010 and UART_STATUS_ADDR = 32'h8000_0014 (the top level decodes sel from these); typedef enum uart_tx_state_t {IDLE, START, DATA, STOP}; STATUS bit-index constants.
- Sub-module sync_fifo (WIDTH=8, DEPTH): push/pop/full/empty/count. It is reusable for a future UART RX.

Test Plan:
- Override CLK_FREQ_HZ=40, BAUD=10 (DIV=4). Write 0xA5 -> after 2 cycles uart_tx reads 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop bit 1. Frame is 40 cycles total; tx_busy then drops.
- Write 0x01, 0x02, 0x03 on consecutive cycles -> three frames with no idle gap between them: the stop bit of the first is immediately followed by a start bit. STATUS count reads 2 just after the first pop.
- Fill with 17 writes while the FSM is held busy (FIFO_DEPTH=16) -> STATUS reads full=1 and overflow=1, and the 17th byte never appears on the line. Writing STATUS 0x8 clears overflow, and full remains set.
- Push into a full FIFO in the cycle the STOP->START pop occurs -> the push is accepted, count stays at 16, and overflow stays 0.
- Assert rst during DATA bit 3 -> uart_tx=1 and STATUS=0x0000_0002 on the next read. A subsequent write of 0x55 is transmitted cleanly.
- Read STATUS with sel=0 -> rdata unchanged. Read TXDATA -> rdata=0, one cycle after re.

Source files
------------

// File: rtl/riscv_pkg.sv
// SoC-wide constants and types shared by the memory-mapped peripherals.
// Holds the UART transmitter's address map, FSM state type and STATUS bit positions.
package riscv_pkg;

  localparam logic [31:0] UART_TXDATA_ADDR = 32'h8000_0010;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h8000_0014;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_ACTIVE  = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_MSB = 12;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read; count/full/empty are registered, 1-cycle push-to-count latency.
// A push while full is accepted only if a pop happens in the same cycle; otherwise it is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // When full with a simultaneous pop, wr_ptr == rd_ptr: the old entry is read before it is overwritten.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// Store-driven 8N1 UART transmitter: a TXDATA store reaches the FIFO count next edge, start bit 2 edges later.
// No backpressure on stores: a store to a full FIFO is dropped and latches a sticky overflow flag.
module uart_tx_mmio
  import riscv_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic        addr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int DIV        = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DIV_LAST_I = DIV - 1;
  localparam logic [CW-1:0] DIV_LAST = DIV_LAST_I[CW-1:0];
  localparam int FW         = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           overflow;

  logic           push_req;
  logic           pop;
  logic           bit_end;
  logic [7:0]     fifo_rdata;
  logic           full;
  logic           empty;
  logic [FW-1:0]  count;
  logic [31:0]    status;

  assign push_req = sel & we & ~addr;
  assign bit_end  = (baud_cnt == DIV_LAST);
  // Pop decisions look only at registered state, so a byte pushed this cycle waits one edge.
  assign pop      = ((state == IDLE) | ((state == STOP) & bit_end)) & ~empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= fifo_rdata;
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= fifo_rdata;
              bit_idx <= '0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line level is re-timed from the current state so the pin is always a flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx <= 1'b1;
    end else begin
      case (state)
        START:   uart_tx <= 1'b0;
        DATA:    uart_tx <= shift[0];
        default: uart_tx <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_req & full & ~pop) begin
      overflow <= 1'b1;
    end else if (sel & we & addr & wdata[STAT_OVF]) begin
      overflow <= 1'b0;
    end
  end

  always_comb begin
    status                            = '0;
    status[STAT_FULL]                 = full;
    status[STAT_EMPTY]                = empty;
    status[STAT_ACTIVE]               = (state != IDLE);
    status[STAT_OVF]                  = overflow;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = 5'(count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (sel & re) begin
      rdata <= addr ? status : 32'd0;
    end
  end

  assign tx_busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio at DIV=4: register vector table, exact-waveform and corner sequences,
// random byte streams checked by a line decoder against a queue of accepted bytes.
module tb_uart_tx_mmio;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        we;
  logic        re;
  logic        addr;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic        uart_tx;
  logic        tx_busy;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          last_wr;
  byte unsigned exp_q[$];
  int          starts[$];

  uart_tx_mmio #(
    .CLK_FREQ_HZ (40),
    .BAUD        (10),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d, input bit acc);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
    if (!a && acc) exp_q.push_back(d);
    last_wr = cyc;
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    sel = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    tick();
    sel = 1'b0; re = 1'b0;
    v = rdata;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && tx_busy; i++) tick();
    check("idle_timeout", {31'b0, tx_busy}, 32'd0);
  endtask

  // Line decoder: samples mid-bit on the falling clock edge, independent of the design's counters.
  logic       mon_act = 1'b0;
  int         mon_cnt;
  logic [7:0] mon_byte;
  logic [8:0] mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (uart_tx === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == DIV / 2) check("start_bit", {31'b0, uart_tx}, 32'd0);
      if (mon_cnt > DIV && mon_cnt < 9 * DIV && (mon_cnt % DIV) == DIV / 2)
        mon_byte[mon_cnt / DIV - 1] = uart_tx;
      if (mon_cnt == 9 * DIV + DIV / 2) begin
        check("stop_bit", {31'b0, uart_tx}, 32'd1);
        mon_exp = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        check("rx_byte", {24'b0, mon_byte}, {23'b0, mon_exp});
        mon_act = 1'b0;
      end
    end
  end

  typedef struct {
    logic        s;
    logic        w;
    logic        r;
    logic        a;
    logic [7:0]  d;
    logic [31:0] exp_rd;
    logic        exp_busy;
  } vec_t;

  vec_t        vt[11];
  logic [31:0] v;
  logic [7:0]  pat;
  logic        eb;
  int          t0;
  int          s0;
  int          len;

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 1'b0; wdata = '0;
    repeat (3) tick();
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    rst = 1'b0;
    tick();

    // {sel, we, re, addr, wdata, expected rdata after the edge, expected tx_busy}
    vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_0002, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_0000, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0000_0000, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_0002, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 32'h0000_0002, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 32'h0000_0002, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_0100, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_0006, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b1};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_0000, 1'b1};
    for (int i = 0; i < 11; i++) begin
      sel = vt[i].s; we = vt[i].w; re = vt[i].r; addr = vt[i].a; wdata = vt[i].d;
      tick();
      if (vt[i].s && vt[i].w && !vt[i].a) exp_q.push_back(vt[i].d);
      check($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rd);
      check($sformatf("vec%0d_busy", i), {31'b0, tx_busy}, {31'b0, vt[i].exp_busy});
    end
    sel = 1'b0; we = 1'b0; re = 1'b0;
    wait_idle(200);

    // Exact 0xA5 frame: line falls two edges after the store, 10*DIV cycles long.
    pat = 8'hA5;
    wr(1'b0, pat, 1'b1);
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k < 2)        eb = 1'b1;
      else if (k <= 5)  eb = 1'b0;
      else if (k <= 37) eb = pat[(k - 6) / 4];
      else              eb = 1'b1;
      check($sformatf("a5_line_k%0d", k), {31'b0, uart_tx}, {31'b0, eb});
      if (k == 40) check("a5_busy_in_stop", {31'b0, tx_busy}, 32'd1);
      if (k == 41) check("a5_busy_after", {31'b0, tx_busy}, 32'd0);
    end
    tick();
    check("a5_line_idle", {31'b0, uart_tx}, 32'd1);

    // Back-to-back frames with no idle gap.
    s0 = starts.size();
    wr(1'b0, 8'h01, 1'b1);
    wr(1'b0, 8'h02, 1'b1);
    wr(1'b0, 8'h03, 1'b1);
    rd(1'b1, v);
    check("b2b_status", v, 32'h0000_0204);
    wait_idle(300);
    check("b2b_frames", starts.size() - s0, 32'd3);
    if (starts.size() >= s0 + 3) begin
      check("b2b_gap1", starts[s0 + 1] - starts[s0], 32'd10 * DIV);
      check("b2b_gap2", starts[s0 + 2] - starts[s0 + 1], 32'd10 * DIV);
    end

    // Overflow while the shifter is busy, then push into a full FIFO on the STOP->START pop.
    wr(1'b0, 8'h10, 1'b1);
    t0 = last_wr;
    tick(); tick();
    for (int i = 0; i < 17; i++) wr(1'b0, 8'h20 + 8'(i), i < 16);
    rd(1'b1, v);
    check("ovf_status", v, 32'h0000_100D);
    wr(1'b1, 8'h08, 1'b0);
    rd(1'b1, v);
    check("ovf_cleared", v, 32'h0000_1005);
    while (cyc < t0 + 40) tick();
    wr(1'b0, 8'h31, 1'b1);
    rd(1'b1, v);
    check("full_push_on_pop", v, 32'h0000_1005);
    wait_idle(17 * 10 * DIV + 200);

    // Reset during data bit 3 aborts the frame.
    wr(1'b0, 8'hC3, 1'b1);
    t0 = last_wr;
    while (cyc < t0 + 17) tick();
    check("pre_rst_line", {31'b0, uart_tx}, 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_line", {31'b0, uart_tx}, 32'd1);
    check("mid_rst_busy", {31'b0, tx_busy}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    rd(1'b1, v);
    check("post_rst_status", v, 32'h0000_0002);
    wr(1'b0, 8'h55, 1'b1);
    wait_idle(200);

    // Random bursts; the accepted-byte queue bounds FIFO occupancy so nothing overflows.
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 6);
      for (int g = 0; g < 600 && exp_q.size() + len > 16; g++) tick();
      for (int j = 0; j < len; j++) begin
        wr(1'b0, 8'($urandom), 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          rd(1'b0, v);
          check("rand_txdata_rd", v, 32'd0);
        end
      end
      repeat ($urandom_range(0, 60)) tick();
    end
    wait_idle(20 * 10 * DIV);
    rd(1'b1, v);
    check("final_status", v, 32'h0000_0002);
    repeat (5) tick();
    check("bytes_outstanding", exp_q.size(), 32'd0);
    check("final_line", {31'b0, uart_tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
